// File: rtl/gate_model_bist_ctrl.sv
// BIST sequencer for 16-in / 10-out combinational gate models: LFSR stimulus,
// programmable settle time, MISR compaction and golden-signature compare.
module gate_model_bist_ctrl #(
  parameter int          NUM_PATTERNS  = 256,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] func_in,
  input  logic [15:0] golden_sig,
  input  logic [9:0]  gm_out,
  output logic [15:0] gm_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  localparam int CW = $clog2(NUM_PATTERNS + 1);
  localparam int WW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(NUM_PATTERNS - 1);
  localparam logic [WW-1:0] WCNT_LAST = WW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Feedback tap of x^16+x^14+x^13+x^11+1, shared by the LFSR and the MISR.
  function automatic logic fb(input logic [15:0] x);
    return x[15] ^ x[13] ^ x[12] ^ x[10];
  endfunction

  state_t        state_q, state_d;
  logic [15:0]   pat_q, pat_d;
  logic [15:0]   misr_q, misr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

  // Next-state and datapath updates for the run sequence.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETTLE;
          pat_d   = LFSR_SEED;
          misr_d  = 16'h0000;
          cnt_d   = '0;
          wcnt_d  = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (wcnt_q == WCNT_LAST) begin
          state_d = ST_CAPTURE;
          wcnt_d  = '0;
        end else begin
          wcnt_d  = wcnt_q + WW'(1);
        end
      end
      ST_CAPTURE: begin
        misr_d = {misr_q[14:0], fb(misr_q)} ^ {6'b000000, gm_out};
        pat_d  = {pat_q[14:0], fb(pat_q)};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        pass_d  = (misr_q == golden_sig);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pat_q   <= 16'h0000;
      misr_q  <= 16'h0000;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign gm_in     = busy_q ? pat_q : func_in;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = misr_q;

endmodule
